// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD read path and its phase timer.
package lcd_pkg;

  typedef enum logic [1:0] {
    RD_STATUS = 2'd0,
    RD_DATA   = 2'd1,
    WAIT_IDLE = 2'd2,
    RSVD      = 2'd3
  } lcd_req_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_GAP,
    ST_RESP
  } lcd_rd_state_e;

  localparam int LCD_BF_BIT  = 7;
  localparam int LCD_AC_W    = 7;
  localparam int LCD_TIMER_W = 16;
  localparam int LCD_POLL_W  = 17;

  // The reserved request code behaves exactly like a status read.
  function automatic lcd_req_kind_e lcd_norm_kind(input logic [1:0] raw);
    lcd_req_kind_e k;
    k = lcd_req_kind_e'(raw);
    if (k == RSVD) k = RD_STATUS;
    return k;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on phase entry makes the phase last exactly N cycles.
module lcd_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// Read-side LCD bus master: BF/AC status read, data RAM read and wait-not-busy polling.
// Optional macro LCD_READ_SYNC_EN adds a 2-flop synchronizer on lcd_data_in.
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = 3,
  parameter int T_PW     = 25,
  parameter int T_H      = 2,
  parameter int T_GAP    = 50,
  parameter int POLL_MAX = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_busy,
  output logic [6:0] rsp_addr,
  output logic       rsp_timeout,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_data_oe
);

  localparam logic [LCD_TIMER_W-1:0] AS_LOAD  = LCD_TIMER_W'(T_AS - 1);
  localparam logic [LCD_TIMER_W-1:0] PW_LOAD  = LCD_TIMER_W'(T_PW - 1);
  localparam logic [LCD_TIMER_W-1:0] H_LOAD   = LCD_TIMER_W'(T_H - 1);
  localparam logic [LCD_TIMER_W-1:0] GAP_LOAD = LCD_TIMER_W'(T_GAP - 1);
  localparam logic [LCD_POLL_W-1:0]  POLL_LIMIT = LCD_POLL_W'(POLL_MAX);

  lcd_rd_state_e            state_q, state_d;
  lcd_req_kind_e            kind_q, kind_d;
  logic [LCD_POLL_W-1:0]    poll_q, poll_d;
  logic [7:0]               cap_q, cap_d;
  logic                     e_q, e_d;
  logic                     rs_q, rs_d;
  logic                     rw_q, rw_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [7:0]               rsp_data_q, rsp_data_d;
  logic                     rsp_busy_q, rsp_busy_d;
  logic [LCD_AC_W-1:0]      rsp_addr_q, rsp_addr_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic                     timer_load;
  logic [LCD_TIMER_W-1:0]   timer_val;
  logic                     timer_done;
  logic [7:0]               sample_data;

`ifdef LCD_READ_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  if (T_PW < 3) begin : g_bad_tpw
    $error("lcd_status_reader: T_PW must be at least 3 with LCD_READ_SYNC_EN");
  end

  always_comb begin
    sync1_d = lcd_data_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_data = sync2_q;
`else
  assign sample_data = lcd_data_in;
`endif

  lcd_phase_timer #(.W(LCD_TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    poll_d        = poll_q;
    cap_d         = cap_q;
    e_d           = e_q;
    rs_d          = rs_q;
    rw_d          = rw_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_busy_d    = rsp_busy_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_load    = 1'b0;
    timer_val     = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          kind_d     = lcd_norm_kind(req_kind);
          poll_d     = '0;
          rw_d       = 1'b1;
          rs_d       = (lcd_norm_kind(req_kind) == RD_DATA);
          e_d        = 1'b0;
          timer_load = 1'b1;
          timer_val  = AS_LOAD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          e_d        = 1'b1;
          timer_load = 1'b1;
          timer_val  = PW_LOAD;
          state_d    = ST_E_HIGH;
        end
      end
      ST_E_HIGH: begin
        if (timer_done) begin
          cap_d      = sample_data;
          poll_d     = poll_q + 1'b1;
          e_d        = 1'b0;
          timer_load = 1'b1;
          timer_val  = H_LOAD;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          // Only a wait-not-busy request re-polls, and only while BF is set and budget remains.
          if (kind_q == WAIT_IDLE && cap_q[LCD_BF_BIT] && poll_q < POLL_LIMIT) begin
            timer_load = 1'b1;
            timer_val  = GAP_LOAD;
            state_d    = ST_GAP;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = AS_LOAD;
          state_d    = ST_SETUP;
        end
      end
      ST_RESP: begin
        rsp_valid_d   = 1'b1;
        rsp_data_d    = cap_q;
        rsp_busy_d    = cap_q[LCD_BF_BIT];
        rsp_addr_d    = cap_q[LCD_AC_W-1:0];
        rsp_timeout_d = (kind_q == WAIT_IDLE) && cap_q[LCD_BF_BIT];
        rw_d          = 1'b0;
        rs_d          = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      kind_q        <= RD_STATUS;
      poll_q        <= '0;
      cap_q         <= '0;
      e_q           <= 1'b0;
      rs_q          <= 1'b0;
      rw_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_busy_q    <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      poll_q        <= poll_d;
      cap_q         <= cap_d;
      e_q           <= e_d;
      rs_q          <= rs_d;
      rw_q          <= rw_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_busy_q    <= rsp_busy_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_busy    = rsp_busy_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign lcd_e       = e_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = rw_q;
  assign lcd_data_oe = 1'b0;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed, table-driven bench for lcd_status_reader with a scripted LCD pad model.
module tb_lcd_status_reader;

  localparam int T_AS     = 3;
  localparam int T_PW     = 25;
  localparam int T_H      = 2;
  localparam int T_GAP    = 50;
  localparam int POLL_MAX = 4;
  localparam int READ_LEN = T_AS + T_PW + T_H;
  localparam int SINGLE   = READ_LEN + 1;
  localparam int POLL4    = READ_LEN + 3 * (T_GAP + READ_LEN) + 1;
  localparam int BUDGET   = 2000;

  logic       clk, rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_kind;
  logic       rsp_valid, rsp_busy, rsp_timeout;
  logic [7:0] rsp_data;
  logic [6:0] rsp_addr;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_data_oe;
  logic [7:0] lcd_data_in;

  int n_checks = 0;
  int n_fail   = 0;
  int oe_err   = 0;
  int e_falls  = 0;

  // Pad model: returns pad_busy for the first busy_reads E pulses after seq_base, then pad_final.
  int         seq_base   = 0;
  int         busy_reads = 0;
  logic [7:0] pad_busy   = 8'h00;
  logic [7:0] pad_final  = 8'h00;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] pad_busy;
    int         busy_reads;
    logic [7:0] pad_final;
    logic       exp_rs;
    logic       exp_busy;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_timeout;
    int         exp_pulses;
    int         exp_lat;
  } vec_t;

  typedef struct {
    int lat;
    int e_hi;
    int pulses;
    int min_gap;
    int rs_err;
    int rw_err;
    int ready_err;
    bit timed_out;
  } mon_t;

  vec_t vecs[7];

  lcd_status_reader #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_GAP(T_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_busy    (rsp_busy),
    .rsp_addr    (rsp_addr),
    .rsp_timeout (rsp_timeout),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data_in (lcd_data_in),
    .lcd_data_oe (lcd_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge lcd_e) e_falls++;

  always @(posedge clk) if (lcd_data_oe !== 1'b0) oe_err++;

  always_comb begin
    lcd_data_in = ((e_falls - seq_base) < busy_reads) ? pad_busy : pad_final;
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) return;
    end
    check_output("wait_ready_bound", 0, 1);
  endtask

  // Observes one operation from just after the accept edge up to the rsp_valid sample.
  task automatic monitor_op(input logic exp_rs, output mon_t m);
    logic prev_e;
    int   low_run;
    m = '{default: 0};
    m.min_gap   = 1000000;
    m.timed_out = 1'b1;
    prev_e  = 1'b0;
    low_run = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      m.lat = i;
      if (rsp_valid === 1'b1) begin
        m.timed_out = 1'b0;
        break;
      end
      if (lcd_e === 1'b1) begin
        if (!prev_e) begin
          m.pulses++;
          if (m.pulses > 1 && low_run < m.min_gap) m.min_gap = low_run;
        end
        m.e_hi++;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_e = lcd_e;
      if (lcd_rw !== 1'b1) m.rw_err++;
      if (lcd_rs !== exp_rs) m.rs_err++;
      if (req_ready !== 1'b0) m.ready_err++;
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    mon_t  m;
    string p;
    logic [7:0] held;
    p = $sformatf("vec%0d", idx);
    wait_ready();
    seq_base   = e_falls;
    busy_reads = v.busy_reads;
    pad_busy   = v.pad_busy;
    pad_final  = v.pad_final;
    req_valid  = 1'b1;
    req_kind   = v.kind;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    monitor_op(v.exp_rs, m);
    if (m.timed_out) begin
      check_output({p, "_rsp_bound"}, 0, 1);
      return;
    end
    check_output({p, "_latency"}, m.lat, v.exp_lat);
    check_output({p, "_pulses"}, m.pulses, v.exp_pulses);
    check_output({p, "_e_high_cycles"}, m.e_hi, T_PW * v.exp_pulses);
    check_output({p, "_rs_err"}, m.rs_err, 0);
    check_output({p, "_rw_err"}, m.rw_err, 0);
    check_output({p, "_ready_err"}, m.ready_err, 0);
    if (m.pulses > 1) check_output({p, "_gap_ok"}, int'(m.min_gap >= T_GAP), 1);
    check_output({p, "_rsp_busy"}, rsp_busy, v.exp_busy);
    check_output({p, "_rsp_addr"}, rsp_addr, v.exp_addr);
    check_output({p, "_rsp_data"}, rsp_data, v.exp_data);
    check_output({p, "_rsp_timeout"}, rsp_timeout, v.exp_timeout);
    check_output({p, "_rw_released"}, lcd_rw, 0);
    check_output({p, "_rs_released"}, lcd_rs, 0);
    held = rsp_data;
    @(posedge clk);
    #1;
    check_output({p, "_rsp_pulse"}, rsp_valid, 0);
    check_output({p, "_rsp_hold"}, rsp_data, held);
  endtask

  initial begin
    mon_t m;
    bit   saw_e;
    int   stray;

    vecs[0] = '{2'd0, 8'h00, 0,  8'h85, 1'b0, 1'b1, 7'h05, 8'h85, 1'b0, 1, SINGLE};
    vecs[1] = '{2'd1, 8'h00, 0,  8'h54, 1'b1, 1'b0, 7'h54, 8'h54, 1'b0, 1, SINGLE};
    vecs[2] = '{2'd3, 8'h00, 0,  8'h2A, 1'b0, 1'b0, 7'h2A, 8'h2A, 1'b0, 1, SINGLE};
    vecs[3] = '{2'd2, 8'h00, 0,  8'h3F, 1'b0, 1'b0, 7'h3F, 8'h3F, 1'b0, 1, SINGLE};
    vecs[4] = '{2'd2, 8'hC0, 3,  8'h40, 1'b0, 1'b0, 7'h40, 8'h40, 1'b0, 4, POLL4};
    vecs[5] = '{2'd2, 8'h80, 99, 8'h80, 1'b0, 1'b1, 7'h00, 8'h80, 1'b1, 4, POLL4};
    vecs[6] = '{2'd0, 8'h00, 0,  8'hFF, 1'b0, 1'b1, 7'h7F, 8'hFF, 1'b0, 1, SINGLE};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_lcd_e", lcd_e, 0);
    check_output("reset_lcd_rs", lcd_rs, 0);
    check_output("reset_lcd_rw", lcd_rw, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_rsp_data", rsp_data, 0);
    check_output("reset_rsp_busy", rsp_busy, 0);
    check_output("reset_rsp_addr", rsp_addr, 0);
    check_output("reset_rsp_timeout", rsp_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_req_ready", req_ready, 1);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

    // Reset asserted while E is high: E must drop without waiting for a clock edge.
    wait_ready();
    seq_base   = e_falls;
    busy_reads = 0;
    pad_final  = 8'h85;
    req_valid  = 1'b1;
    req_kind   = 2'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    saw_e = 1'b0;
    for (int i = 0; i < 20 && !saw_e; i++) begin
      @(posedge clk);
      #1;
      if (lcd_e === 1'b1) saw_e = 1'b1;
    end
    check_output("rst_mid_e_seen", saw_e, 1);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_e_async", lcd_e, 0);
    check_output("rst_mid_rw_async", lcd_rw, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_mid_ready", req_ready, 1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) stray++;
    end
    check_output("rst_mid_no_rsp", stray, 0);
    apply_stimulus(vecs[0], 10);

    // req_valid held through a busy data read; a queued reserved kind must act as a status read.
    wait_ready();
    seq_base   = e_falls;
    busy_reads = 0;
    pad_final  = 8'h11;
    req_valid  = 1'b1;
    req_kind   = 2'd1;
    @(posedge clk);
    #1;
    req_kind = 2'd3;
    check_output("queue_first_busy", req_ready, 0);
    monitor_op(1'b1, m);
    check_output("queue_first_bound", int'(m.timed_out), 0);
    check_output("queue_first_latency", m.lat, SINGLE);
    check_output("queue_first_rs_err", m.rs_err, 0);
    check_output("queue_first_ready_err", m.ready_err, 0);
    check_output("queue_first_data", rsp_data, 8'h11);
    pad_final = 8'h92;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_output("queue_second_accepted", req_ready, 0);
    monitor_op(1'b0, m);
    check_output("queue_second_bound", int'(m.timed_out), 0);
    check_output("queue_second_latency", m.lat, SINGLE);
    check_output("queue_second_rs_err", m.rs_err, 0);
    check_output("queue_second_pulses", m.pulses, 1);
    check_output("queue_second_busy", rsp_busy, 1);
    check_output("queue_second_addr", rsp_addr, 7'h12);
    check_output("queue_second_timeout", rsp_timeout, 0);

    check_output("data_oe_low", oe_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
